sw_key_ctrl: RTL and testbench

Board-input front end and the input-side counterpart of the LED output driver. It samples the ten slide switches (`sw_0`..`sw_9`) and four push keys (`key_0`..`key_3`, active-low at the pin) and synchronises and debounces each one. It presents the switches as a level register and the keys as a level register plus sticky press flags with write-one-to-clear and an interrupt line. The MMIO bus decoder reads its outputs the same way it writes the LED register.

---
 rtl/sw_key_ctrl_pkg.sv | 17 +
 rtl/sw_key_ctrl_debounce.sv | 57 +++++
 rtl/sw_key_ctrl.sv | 86 ++++++++
 tb/tb_sw_key_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sw_key_ctrl_pkg.sv
// Shared widths and defaults for the board-input front end and its LED sibling.
// Constants only, no logic.
// Imported by the debounce channel and the sw_key_ctrl top level.
package sw_key_ctrl_pkg;

    localparam int SW_REG_WIDTH  = 10;
    localparam int KEY_REG_WIDTH = 4;
    localparam int LED_REG_WIDTH = 10;

    // 10 ms at 50 MHz; the counter width must be able to hold DEBOUNCE_CYCLES-1
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int CNT_WIDTH_DEFAULT       = 20;

    // Switches occupy the low channel indices, keys the high ones
    localparam int NUM_CHANNELS = SW_REG_WIDTH + KEY_REG_WIDTH;

endpackage

// File: rtl/sw_key_ctrl_debounce.sv
// Single-bit input channel: 2-flop synchroniser, disagreement counter, stable register.
// Stable output flips DEBOUNCE_CYCLES+1 edges after the first edge sampling a steady new level.
// No backpressure; the channel free-runs every cycle.
module sw_key_ctrl_debounce
    import sw_key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic dout_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 s1_q;
    logic                 s2_q;
    logic                 st_q;
    logic                 st_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Qualify a level change only after DEBOUNCE_CYCLES consecutive disagreeing cycles;
    // any agreeing cycle restarts the count, so the counter can never wrap
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (s2_q == st_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            st_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, counter and stable register; reset discards any count in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            st_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= din_i;
            s2_q  <= s1_q;
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o = st_q;

endmodule

// File: rtl/sw_key_ctrl.sv
// Debounced switch/key registers with key press pulses, sticky W1C press flags and an IRQ.
// Levels qualify DEBOUNCE_CYCLES+1 edges after a steady pin change; pulse/press one edge later.
// No backpressure; a press and a clear in the same cycle keep the flag set.
module sw_key_ctrl
    import sw_key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sw_0,
    input  logic                     sw_1,
    input  logic                     sw_2,
    input  logic                     sw_3,
    input  logic                     sw_4,
    input  logic                     sw_5,
    input  logic                     sw_6,
    input  logic                     sw_7,
    input  logic                     sw_8,
    input  logic                     sw_9,
    input  logic                     key_0,
    input  logic                     key_1,
    input  logic                     key_2,
    input  logic                     key_3,
    output logic [SW_REG_WIDTH-1:0]  sw_reg,
    output logic [KEY_REG_WIDTH-1:0] key_reg,
    output logic [KEY_REG_WIDTH-1:0] key_pulse,
    output logic [KEY_REG_WIDTH-1:0] key_press,
    input  logic [KEY_REG_WIDTH-1:0] key_press_clr,
    output logic                     key_irq
);

    logic [NUM_CHANNELS-1:0]  raw_in;
    logic [NUM_CHANNELS-1:0]  stable;
    logic [KEY_REG_WIDTH-1:0] key_rise;
    logic [KEY_REG_WIDTH-1:0] key_reg_d_q;
    logic [KEY_REG_WIDTH-1:0] key_pulse_q;
    logic [KEY_REG_WIDTH-1:0] key_press_q;
    logic [KEY_REG_WIDTH-1:0] key_press_d;

    // Keys are active-low at the pin; invert here so every channel is active-high
    assign raw_in = {~key_3, ~key_2, ~key_1, ~key_0,
                     sw_9, sw_8, sw_7, sw_6, sw_5, sw_4, sw_3, sw_2, sw_1, sw_0};

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        sw_key_ctrl_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .din_i  (raw_in[i]),
            .dout_o (stable[i])
        );
    end

    assign sw_reg  = stable[SW_REG_WIDTH-1:0];
    assign key_reg = stable[NUM_CHANNELS-1:SW_REG_WIDTH];

    // Press edge of the debounced level; releases are ignored
    assign key_rise = key_reg & ~key_reg_d_q;

    // Clear first, then set, so a press coinciding with a clear strobe is not lost
    always_comb begin
        key_press_d = (key_press_q & ~key_press_clr) | key_rise;
    end

    // Delayed key level, registered press pulse and sticky press flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg_d_q <= '0;
            key_pulse_q <= '0;
            key_press_q <= '0;
        end else begin
            key_reg_d_q <= key_reg;
            key_pulse_q <= key_rise;
            key_press_q <= key_press_d;
        end
    end

    assign key_pulse = key_pulse_q;
    assign key_press = key_press_q;
    assign key_irq   = |key_press_q;

endmodule

// File: tb/tb_sw_key_ctrl.sv
// Directed bench for sw_key_ctrl with DEBOUNCE_CYCLES = 4.
// Expected outputs are queued per cycle as stimulus is driven and popped after the edge.
module tb_sw_key_ctrl;

    localparam int DBC = 4;

    typedef struct {
        string      tag;
        logic [9:0] sw;
        logic [3:0] kreg;
        logic [3:0] kpulse;
        logic [3:0] kpress;
        logic       irq;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sw;
    logic [3:0] key;
    logic [3:0] clr;
    logic [9:0] sw_reg;
    logic [3:0] key_reg;
    logic [3:0] key_pulse;
    logic [3:0] key_press;
    logic       key_irq;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sw_key_ctrl #(
        .DEBOUNCE_CYCLES (DBC),
        .CNT_WIDTH       (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_0          (sw[0]),
        .sw_1          (sw[1]),
        .sw_2          (sw[2]),
        .sw_3          (sw[3]),
        .sw_4          (sw[4]),
        .sw_5          (sw[5]),
        .sw_6          (sw[6]),
        .sw_7          (sw[7]),
        .sw_8          (sw[8]),
        .sw_9          (sw[9]),
        .key_0         (key[0]),
        .key_1         (key[1]),
        .key_2         (key[2]),
        .key_3         (key[3]),
        .sw_reg        (sw_reg),
        .key_reg       (key_reg),
        .key_pulse     (key_pulse),
        .key_press     (key_press),
        .key_press_clr (clr),
        .key_irq       (key_irq)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [9:0] s, input logic [3:0] kr,
                        input logic [3:0] kp, input logic [3:0] kpr, input logic irq);
        exp_t e;
        e.tag = tag; e.sw = s; e.kreg = kr; e.kpulse = kp; e.kpress = kpr; e.irq = irq;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_underflow observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".sw_reg"},    32'(sw_reg),    32'(e.sw));
            cmp({e.tag, ".key_reg"},   32'(key_reg),   32'(e.kreg));
            cmp({e.tag, ".key_pulse"}, 32'(key_pulse), 32'(e.kpulse));
            cmp({e.tag, ".key_press"}, 32'(key_press), 32'(e.kpress));
            cmp({e.tag, ".key_irq"},   32'(key_irq),   32'(e.irq));
        end
    endtask

    // One clock edge: queue what should appear after it, then sample #1 past the edge
    task automatic cyc(input string tag, input logic [9:0] s, input logic [3:0] kr,
                       input logic [3:0] kp, input logic [3:0] kpr, input logic irq);
        push(tag, s, kr, kp, kpr, irq);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst = 1'b1;
        sw  = '0;
        key = 4'hF;
        clr = '0;

        // Reset state
        @(posedge clk); #1;
        push("reset", 10'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        pop_check();
        cyc("reset_hold", 10'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) cyc("idle", 10'h0, 4'h0, 4'h0, 4'h0, 1'b0);

        // sw_3 rises: sw_reg changes exactly at E0+DBC+1
        sw[3] = 1'b1;
        for (int k = 0; k <= DBC + 1; k++)
            cyc($sformatf("sw3_e%0d", k), (k == DBC + 1) ? 10'h008 : 10'h000,
                4'h0, 4'h0, 4'h0, 1'b0);

        // key_1 glitch of DBC-1 cycles never qualifies
        key[1] = 1'b0;
        for (int k = 0; k < DBC - 1; k++) cyc("glitch_low", 10'h008, 4'h0, 4'h0, 4'h0, 1'b0);
        key[1] = 1'b1;
        for (int k = 0; k < 10; k++) cyc("glitch_after", 10'h008, 4'h0, 4'h0, 4'h0, 1'b0);

        // key_1 held: level at E0+5, single pulse and sticky flag at E0+6
        key[1] = 1'b0;
        for (int k = 0; k < 10; k++)
            cyc($sformatf("key1_e%0d", k), 10'h008,
                (k >= 5) ? 4'h2 : 4'h0,
                (k == 6) ? 4'h2 : 4'h0,
                (k >= 6) ? 4'h2 : 4'h0,
                k >= 6);

        // Write-one-to-clear drops the flag and the IRQ on the sampling edge
        clr = 4'b0010;
        cyc("key1_clr", 10'h008, 4'h2, 4'h0, 4'h0, 1'b0);
        clr = 4'b0000;

        // Release produces no pulse and no flag
        key[1] = 1'b1;
        for (int k = 0; k < 8; k++)
            cyc($sformatf("key1_rel_e%0d", k), 10'h008,
                (k >= 5) ? 4'h0 : 4'h2, 4'h0, 4'h0, 1'b0);

        // Clear strobe on the same edge as the pulse: set wins
        key[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 6) clr = 4'b0100;
            cyc($sformatf("key2_e%0d", k), 10'h008,
                (k >= 5) ? 4'h4 : 4'h0,
                (k == 6) ? 4'h4 : 4'h0,
                (k >= 6) ? 4'h4 : 4'h0,
                k >= 6);
            if (k == 6) clr = 4'b0000;
        end
        clr = 4'b0100;
        cyc("key2_clr", 10'h008, 4'h4, 4'h0, 4'h0, 1'b0);
        clr = 4'b0000;
        key[2] = 1'b1;
        for (int k = 0; k < 8; k++)
            cyc($sformatf("key2_rel_e%0d", k), 10'h008,
                (k >= 5) ? 4'h0 : 4'h4, 4'h0, 4'h0, 1'b0);

        // sw_5 reset mid-debounce: after edges E0..E0+3 the count is 2
        sw[5] = 1'b1;
        for (int k = 0; k < 4; k++) cyc("sw5_pre", 10'h008, 4'h0, 4'h0, 4'h0, 1'b0);
        rst = 1'b1;
        #1;
        push("sw5_in_reset", 10'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        pop_check();
        cyc("sw5_reset_hold", 10'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        cyc("sw5_reset_hold", 10'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
        // Both held switches re-qualify in full after reset
        for (int k = 0; k <= DBC + 1; k++)
            cyc($sformatf("sw5_post_e%0d", k), (k == DBC + 1) ? 10'h028 : 10'h000,
                4'h0, 4'h0, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) cyc("sw5_steady", 10'h028, 4'h0, 4'h0, 4'h0, 1'b0);

        cmp("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
